bcd_alarm_display: RTL and testbench

BCD_ALARM_DISPLAY -- requirements
Module: bcd_alarm_display

---
 rtl/bcd_alarm_display.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bcd_alarm_display.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alarm_display.sv
// Purpose : seconds counter in BCD with an alarm comparator, buzzer tone and a
//           multiplexed active-low 7-segment display driver.
// Latency : sec_tick is combinational. count, led_debug, buzz, seg and dig are
//           registered. RING is entered one cycle after a tick-driven match.
// Backpressure: none. The block free-runs from en/clr and accepts a write on
//           any cycle.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-low reset
//   i_en, i_clr       count enable; synchronous clear of prescaler and count
//   i_alm_wr/_val     load strobe and BCD alarm value (digit 0 in [3:0])
//   i_alm_ack         silences and disarms the alarm
//   o_count           BCD count; o_sec_tick one pulse per second
//   o_led_debug       toggles on each tick; o_buzz tone while ringing
//   o_seg, o_dig      active-low segments {a..g,dp} and one-hot digit select
//
// Build option: define BLANK_LEADING_ZEROS_EN to blank the zero digits above
// the most significant non-zero digit. Digit 0 is always shown.
module bcd_alarm_display #(
    parameter int CLK_HZ    = 50000000,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int TONE_DIV  = 25000,
    parameter int RING_SECS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_alm_wr,
    input  logic [4*DIGITS-1:0]   i_alm_val,
    input  logic                  i_alm_ack,
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_sec_tick,
    output logic                  o_led_debug,
    output logic                  o_buzz,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_dig
);

    localparam int CW  = 4 * DIGITS;
    localparam int PW  = (CLK_HZ   > 1) ? $clog2(CLK_HZ)   : 1;
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int RW  = $clog2(RING_SECS + 1);
    localparam int SLW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0]  SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0]  TONE_MAX  = TW'(TONE_DIV - 1);
    localparam logic [RW-1:0]  RING_MAX  = RW'(RING_SECS - 1);
    localparam logic [SLW-1:0] SLOT_MAX  = SLW'(DIGITS - 1);

    typedef enum logic {IDLE = 1'b0, RING = 1'b1} state_t;

    // Registers
    state_t            r_state;
    logic [PW-1:0]     r_presc;
    logic [CW-1:0]     r_count;
    logic              r_led;
    logic              r_tick_d;     // last count update came from a tick
    logic [CW-1:0]     r_alm;
    logic              r_armed;
    logic [RW-1:0]     r_ring_cnt;
    logic [TW-1:0]     r_tone_cnt;
    logic              r_buzz;
    logic [SW-1:0]     r_scan_cnt;
    logic [SLW-1:0]    r_slot;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_dig;

    // Combinational
    logic              w_tick;
    logic              w_alm_valid;
    logic [CW-1:0]     w_count_nxt;
    state_t            w_state_nxt;
    logic              w_armed_nxt;
    logic              w_load;
    logic              w_ring_start;
    logic              w_ring_stop;
    logic [SLW-1:0]    w_slot_nxt;
    logic [DIGITS-1:0] w_lz;
    logic [3:0]        w_digit;
    logic [7:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_dig_nxt;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] c);
        logic [CW-1:0] v;
        logic          carry;
        v     = c;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    v[4*i +: 4] = 4'd0;
                end else begin
                    v[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return v;
    endfunction

    // Active-low {a,b,c,d,e,f,g,dp}, dp off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Tick, write validation and next count. clr beats the tick.
    always_comb begin
        w_tick      = i_rst && i_en && !i_clr && (r_presc == PRESC_MAX);
        w_alm_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_alm_val[4*i +: 4] > 4'd9) w_alm_valid = 1'b0;
        end
        if (i_clr)       w_count_nxt = '0;
        else if (w_tick) w_count_nxt = bcd_inc(r_count);
        else             w_count_nxt = r_count;
    end

    // Alarm FSM. Ack outranks a write; a write outranks a pending match.
    always_comb begin
        w_state_nxt  = r_state;
        w_armed_nxt  = r_armed;
        w_load       = 1'b0;
        w_ring_start = 1'b0;
        w_ring_stop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_alm_ack) begin
                    w_armed_nxt = 1'b0;
                end else if (i_alm_wr) begin
                    if (w_alm_valid) begin
                        w_load      = 1'b1;
                        w_armed_nxt = 1'b1;
                    end
                end else if (r_tick_d && r_armed && (r_count == r_alm)) begin
                    // Only a tick-driven update may ring; clr and writes
                    // never set r_tick_d.
                    w_state_nxt  = RING;
                    w_ring_start = 1'b1;
                end
            end
            RING: begin
                if (i_alm_ack) begin
                    w_state_nxt = IDLE;
                    w_armed_nxt = 1'b0;
                    w_ring_stop = 1'b1;
                end else if (i_alm_wr) begin
                    // Leaving RING disarms; a valid write re-arms with the
                    // new value.
                    w_state_nxt = IDLE;
                    w_ring_stop = 1'b1;
                    w_load      = w_alm_valid;
                    w_armed_nxt = w_alm_valid;
                end else if (w_tick && (r_ring_cnt == RING_MAX)) begin
                    w_state_nxt = IDLE;
                    w_armed_nxt = 1'b0;
                    w_ring_stop = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Display: seg/dig are built from the next slot and next count so both
    // registers always describe the same digit.
    always_comb begin
        w_slot_nxt = r_slot;
        if (r_scan_cnt == SCAN_MAX) begin
            w_slot_nxt = (r_slot == SLOT_MAX) ? '0 : r_slot + 1'b1;
        end
        w_digit = w_count_nxt[4*int'(w_slot_nxt) +: 4];

        w_lz = '0;
`ifdef BLANK_LEADING_ZEROS_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_run = zero_run && (w_count_nxt[4*i +: 4] == 4'd0);
                w_lz[i]  = zero_run;
            end
        end
`endif

        w_dig_nxt             = '1;
        w_dig_nxt[w_slot_nxt] = 1'b0;
        w_seg_nxt             = seg_decode(w_digit);
        if (w_slot_nxt == '0) w_seg_nxt[0] = ~w_armed_nxt;
        if (w_lz[w_slot_nxt]) w_seg_nxt = 8'hFF;
    end

    // Counting path
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_presc  <= '0;
            r_count  <= '0;
            r_led    <= 1'b0;
            r_tick_d <= 1'b0;
        end else begin
            if (i_clr)                      r_presc <= '0;
            else if (w_tick)                r_presc <= '0;
            else if (i_en)                  r_presc <= r_presc + 1'b1;
            r_count  <= w_count_nxt;
            r_tick_d <= w_tick;
            if (w_tick) r_led <= ~r_led;
        end
    end

    // Alarm state, ring timing and tone
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_alm      <= '0;
            r_armed    <= 1'b0;
            r_ring_cnt <= '0;
            r_tone_cnt <= '0;
            r_buzz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
            if (w_load) r_alm <= i_alm_val;
            if (w_ring_start) begin
                r_buzz     <= 1'b1;
                r_tone_cnt <= '0;
                r_ring_cnt <= '0;
            end else if (w_ring_stop) begin
                r_buzz     <= 1'b0;
                r_tone_cnt <= '0;
                r_ring_cnt <= '0;
            end else if (r_state == RING) begin
                if (r_tone_cnt == TONE_MAX) begin
                    r_tone_cnt <= '0;
                    r_buzz     <= ~r_buzz;
                end else begin
                    r_tone_cnt <= r_tone_cnt + 1'b1;
                end
                if (w_tick) r_ring_cnt <= r_ring_cnt + 1'b1;
            end
        end
    end

    // Scan and display registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_scan_cnt <= '0;
            r_slot     <= '0;
            r_seg      <= 8'h03;
            r_dig      <= ~DIGITS'(1);
        end else begin
            r_scan_cnt <= (r_scan_cnt == SCAN_MAX) ? '0 : r_scan_cnt + 1'b1;
            r_slot     <= w_slot_nxt;
            r_seg      <= w_seg_nxt;
            r_dig      <= w_dig_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_sec_tick  = w_tick;
    assign o_led_debug = r_led;
    assign o_buzz      = r_buzz;
    assign o_seg       = r_seg;
    assign o_dig       = r_dig;

endmodule

// File: tb/tb_bcd_alarm_display.sv
module tb_bcd_alarm_display;

    localparam int A_HZ = 10;
    localparam int A_DG = 2;
    localparam int SD   = 2;
    localparam int TD   = 3;
    localparam int RS   = 10;
    localparam int B_HZ = 2;
    localparam int B_DG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_en, a_clr, a_wr, a_ack;
    logic [7:0]  a_val;
    logic [7:0]  a_count;
    logic        a_tick, a_led, a_buzz;
    logic [7:0]  a_seg;
    logic [1:0]  a_dig;

    logic        b_en;
    logic [15:0] b_count;
    logic        b_tick, b_led, b_buzz;
    logic [7:0]  b_seg;
    logic [3:0]  b_dig;

    bcd_alarm_display #(.CLK_HZ(A_HZ), .DIGITS(A_DG), .SCAN_DIV(SD),
                        .TONE_DIV(TD), .RING_SECS(RS)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(a_en), .i_clr(a_clr),
        .i_alm_wr(a_wr), .i_alm_val(a_val), .i_alm_ack(a_ack),
        .o_count(a_count), .o_sec_tick(a_tick), .o_led_debug(a_led),
        .o_buzz(a_buzz), .o_seg(a_seg), .o_dig(a_dig));

    bcd_alarm_display #(.CLK_HZ(B_HZ), .DIGITS(B_DG), .SCAN_DIV(SD),
                        .TONE_DIV(TD), .RING_SECS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_clr(1'b0),
        .i_alm_wr(1'b0), .i_alm_val(16'h0000), .i_alm_ack(1'b0),
        .o_count(b_count), .o_sec_tick(b_tick), .o_led_debug(b_led),
        .o_buzz(b_buzz), .o_seg(b_seg), .o_dig(b_dig));

    // Reference model state (decimal count, cycles since reset, ring age)
    int  m_presc, m_cnt, m_alm, m_ring_cyc, m_ring_ticks, m_cyc;
    bit  m_armed, m_ring, m_pend, m_led;
    logic [7:0] seg_tbl [10];

    int   n_chk = 0;
    int   n_err = 0;
    logic last_tick;

    typedef struct {
        logic       en;
        logic [3:0] dig;
        logic [7:0] seg;
    } scan_vec_t;
    scan_vec_t svec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic compare_a();
        int         slot, dval;
        logic [7:0] es;
        logic [1:0] ed;
        slot = (m_cyc / SD) % A_DG;
        dval = (m_cnt / pow10(slot)) % 10;
        es   = seg_tbl[dval];
        if (slot == 0) es[0] = ~m_armed;
`ifdef BLANK_LEADING_ZEROS_EN
        if (slot > 0 && m_cnt < pow10(slot)) es = 8'hFF;
`endif
        ed       = 2'b11;
        ed[slot] = 1'b0;
        chk("count", a_count, to_bcd2(m_cnt));
        chk("sec_tick", a_tick, rst && a_en && !a_clr && (m_presc == A_HZ - 1));
        chk("led_debug", a_led, m_led);
        chk("buzz", a_buzz, m_ring && (((m_ring_cyc / TD) % 2) == 0));
        chk("seg", a_seg, es);
        chk("dig", a_dig, ed);
    endtask

    task automatic model_step();
        bit tk, vld;
        int val;
        if (!rst) begin
            m_presc = 0; m_cnt = 0; m_alm = 0; m_armed = 0; m_ring = 0;
            m_pend = 0; m_led = 0; m_ring_cyc = 0; m_ring_ticks = 0; m_cyc = 0;
            return;
        end
        tk  = a_en && !a_clr && (m_presc == A_HZ - 1);
        vld = (a_val[7:4] <= 4'd9) && (a_val[3:0] <= 4'd9);
        val = int'(a_val[7:4]) * 10 + int'(a_val[3:0]);
        if (!m_ring) begin
            if (a_ack) m_armed = 0;
            else if (a_wr) begin
                if (vld) begin m_alm = val; m_armed = 1; end
            end else if (m_pend && m_armed && m_cnt == m_alm) begin
                m_ring = 1; m_ring_cyc = 0; m_ring_ticks = 0;
            end
        end else if (a_ack) begin
            m_ring = 0; m_armed = 0;
        end else if (a_wr) begin
            m_ring = 0; m_armed = vld;
            if (vld) m_alm = val;
        end else if (tk && (m_ring_ticks + 1 == RS)) begin
            m_ring = 0; m_armed = 0;
        end else begin
            m_ring_cyc++;
            if (tk) m_ring_ticks++;
        end
        m_pend = tk;
        if (tk) m_led = !m_led;
        if (a_clr) begin
            m_presc = 0; m_cnt = 0;
        end else if (a_en) begin
            if (m_presc == A_HZ - 1) begin m_presc = 0; m_cnt = (m_cnt + 1) % 100; end
            else m_presc++;
        end
        m_cyc++;
    endtask

    // Inputs are set just after a falling edge; outputs checked 1 ns later.
    task automatic cycle();
        #1;
        last_tick = a_tick;
        compare_a();
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_count(input logic [7:0] v, input int limit, input string nm);
        int n;
        n = 0;
        while (a_count !== v && n < limit) begin cycle(); n++; end
        chk(nm, a_count, v);
    endtask

    task automatic wait_buzz(input int limit, input string nm);
        int n;
        n = 0;
        while (a_buzz !== 1'b1 && n < limit) begin cycle(); n++; end
        chk(nm, a_buzz, 1'b1);
    endtask

    initial begin
        int ticks, first, prev, gap_bad, c_idx, b_idx, nbuzz, n;
        seg_tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        // Count 0042 scanned from slot 0: each slot held for two cycles.
        svec[0] = '{1'b0, 4'b1110, 8'h25};
        svec[1] = '{1'b0, 4'b1110, 8'h25};
        svec[2] = '{1'b0, 4'b1101, 8'h99};
        svec[3] = '{1'b0, 4'b1101, 8'h99};
`ifdef BLANK_LEADING_ZEROS_EN
        svec[4] = '{1'b0, 4'b1011, 8'hFF};
        svec[5] = '{1'b0, 4'b1011, 8'hFF};
        svec[6] = '{1'b0, 4'b0111, 8'hFF};
        svec[7] = '{1'b0, 4'b0111, 8'hFF};
`else
        svec[4] = '{1'b0, 4'b1011, 8'h03};
        svec[5] = '{1'b0, 4'b1011, 8'h03};
        svec[6] = '{1'b0, 4'b0111, 8'h03};
        svec[7] = '{1'b0, 4'b0111, 8'h03};
`endif

        rst = 1'b0; a_en = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_ack = 1'b0;
        a_val = 8'h00; b_en = 1'b0;
        @(negedge clk); model_step();
        @(negedge clk); model_step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_count", a_count, 8'h00);
        chk("rst_seg", a_seg, 8'h03);
        chk("rst_dig", a_dig, 2'b10);
        chk("rst_buzz", a_buzz, 1'b0);
        chk("rst_led", a_led, 1'b0);
        chk("rst_tick", a_tick, 1'b0);
        chk("rst_b_seg", b_seg, 8'h03);
        chk("rst_b_dig", b_dig, 4'b1110);
        chk("rst_b_count", b_count, 16'h0000);

        // 1000 enabled cycles: 100 ticks, ten cycles apart, count wraps to 00.
        a_en = 1'b1;
        ticks = 0; first = -1; prev = -1; gap_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (last_tick) begin
                ticks++;
                if (first < 0) first = i;
                if (prev >= 0 && i - prev != A_HZ) gap_bad++;
                prev = i;
            end
        end
        chk("first_tick_cycle", first, 9);
        chk("tick_total", ticks, 100);
        chk("tick_gap_errors", gap_bad, 0);
        chk("wrap_count", a_count, 8'h00);
        chk("led_after_100", a_led, 1'b0);

        // Alarm at 05: ringing starts the cycle after the count shows 05.
        a_wr = 1'b1; a_val = 8'h05;
        cycle();
        a_wr = 1'b0;
        c_idx = -1; b_idx = -1; n = 0;
        while (b_idx < 0 && n < 200) begin
            cycle();
            if (a_count == 8'h05 && c_idx < 0) c_idx = n;
            if (a_buzz && b_idx < 0) b_idx = n;
            n++;
        end
        chk("ring_entry_cycle", b_idx, c_idx + 1);
        wait_count(8'h16, 300, "reach_16");
        nbuzz = 0;
        for (int i = 0; i < 30; i++) begin cycle(); if (a_buzz) nbuzz++; end
        chk("ring_timed_out", nbuzz, 0);

        // Re-arm at 05, ack while ringing, no retrigger on the next wrap.
        a_wr = 1'b1; a_val = 8'h05;
        cycle();
        a_wr = 1'b0;
        wait_buzz(1200, "ring_again");
        for (int i = 0; i < 4; i++) cycle();
        a_ack = 1'b1;
        cycle();
        a_ack = 1'b0;
        chk("ack_buzz_off", a_buzz, 1'b0);
        nbuzz = 0;
        for (int i = 0; i < 1000; i++) begin cycle(); if (a_buzz) nbuzz++; end
        chk("no_retrigger", nbuzz, 0);

        // Invalid write leaves an armed 50 untouched.
        a_wr = 1'b1; a_val = 8'h50;
        cycle();
        a_val = 8'h1A;
        cycle();
        a_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (a_dig == 2'b10) chk("armed_kept_dp", a_seg[0], 1'b0);
        end

        // clr at 37 in the tick cycle: no tick, count 00.
        wait_count(8'h37, 1500, "reach_37");
        n = 0;
        while (m_presc != A_HZ - 1 && n < 20) begin cycle(); n++; end
        a_clr = 1'b1;
        cycle();
        a_clr = 1'b0;
        chk("clr_no_tick", last_tick, 1'b0);
        chk("clr_count", a_count, 8'h00);

        // Ringing from 50; reset at 58.
        wait_count(8'h58, 800, "reach_58");
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("midring_rst_count", a_count, 8'h00);
        chk("midring_rst_buzz", a_buzz, 1'b0);
        chk("midring_rst_seg", a_seg, 8'h03);
        chk("midring_rst_dig", a_dig, 2'b10);
        chk("midring_rst_led", a_led, 1'b0);
        a_en = 1'b0;
        nbuzz = 0;
        for (int i = 0; i < 20; i++) begin cycle(); if (a_buzz) nbuzz++; end
        chk("rst_silenced", nbuzz, 0);

        // Second instance: hold 0042 and walk the scan table.
        b_en = 1'b1;
        n = 0;
        while (b_count !== 16'h0042 && n < 200) begin cycle(); n++; end
        b_en = 1'b0;
        chk("b_reach_0042", b_count, 16'h0042);
        n = 0;
        while ((m_cyc % (SD * B_DG)) != 0 && n < 20) begin cycle(); n++; end
        for (int i = 0; i < 8; i++) begin
            b_en = svec[i].en;
            chk("scan_dig", b_dig, svec[i].dig);
            chk("scan_seg", b_seg, svec[i].seg);
            cycle();
        end
        chk("b_count_held", b_count, 16'h0042);
        chk("b_led", b_led, 1'b0);
        chk("b_buzz", b_buzz, 1'b0);
        chk("b_tick", b_tick, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            a_en  = ($urandom_range(9, 0) != 0);
            a_clr = ($urandom_range(199, 0) == 0);
            a_wr  = ($urandom_range(149, 0) == 0);
            a_ack = ($urandom_range(299, 0) == 0);
            if ($urandom_range(1, 0) == 1) a_val = to_bcd2((m_cnt + 2) % 100);
            else                           a_val = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
